// File: rtl/fp_sample_tx.sv
// ---------------------------------------------------------------------------
// fp_sample_tx
//
// Burst producer for the calibration datapath. A `go` pulse starts a burst
// of BURST_LEN signed ADC samples pulled over a ready/valid handshake. Each
// sample is converted exactly to IEEE-754 single precision by a two-stage
// pipeline and emitted on a data/valid stream that has no backpressure.
//
// Parameters
//   SAMPLE_W   signed sample width (2..24, so the conversion never rounds)
//   BURST_LEN  samples accepted per go (1..65535)
//   SCALE_EXP  exponent decrement, used only when FP_TX_SCALE_EN is defined
//
// Build option
//   FP_TX_SCALE_EN  when defined, the output is multiplied by 2^-SCALE_EXP.
//                   When undefined, the output is the exact integer value.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   go         start pulse, only looked at in IDLE
//   adc_data   two's-complement sample
//   adc_valid  adc_data is valid
//   adc_ready  block accepts a sample this cycle
//   data       single-precision result
//   valid      data is valid this cycle (qualifier only, no backpressure)
//   busy       high while a burst is being accepted or flushed
//   done       one-cycle pulse after the last word of a burst
// ---------------------------------------------------------------------------
module fp_sample_tx #(
    parameter int SAMPLE_W  = 16,
    parameter int BURST_LEN = 16,
    parameter int SCALE_EXP = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                go,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    output logic                adc_ready,
    output logic [31:0]         data,
    output logic                valid,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int P_W   = $clog2(SAMPLE_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               accept;

    // Stage 1: sign, magnitude, leading-one position, zero flag
    logic               s1_valid_reg;
    logic               s1_sign_reg;
    logic [SAMPLE_W-1:0] s1_abs_reg;
    logic [P_W-1:0]     s1_p_reg;
    logic               s1_zero_reg;

    // Stage 2 is the output register itself
    logic               valid_reg;
    logic [31:0]        data_reg;

    // Combinational front end of stage 1
    logic [SAMPLE_W-1:0] abs_next;
    logic [P_W-1:0]      p_next;

    // Combinational front end of stage 2
    logic [22:0]        mant_next;
    logic [7:0]         exp_next;
    logic [31:0]        word_next;

    // ------------------------------------------------------------------
    // Handshake and status, all derived from registered state only
    // ------------------------------------------------------------------
    assign adc_ready = (state_reg == RUN) && (cnt_reg < LAST_CNT);
    assign accept    = adc_valid && adc_ready;
    assign busy      = (state_reg == RUN) || (state_reg == FLUSH);
    assign done      = (state_reg == DONE);
    assign valid     = valid_reg;
    assign data      = data_reg;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (go) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == LAST_CNT - CNT_W'(1)) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // No new samples enter during FLUSH, so once stage 1 is
                // empty both stage valids are 0 after this edge and the
                // last word is on the output now. done then lands in the
                // cycle right after the last valid word.
                if (!s1_valid_reg) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage 1 combinational: magnitude and leading-one search
    // ------------------------------------------------------------------
    always_comb begin
        // Unsigned magnitude keeps the most-negative sample representable
        abs_next = adc_data[SAMPLE_W-1] ? (~adc_data + SAMPLE_W'(1)) : adc_data;
        p_next   = '0;
        // Highest set bit wins because it is assigned last
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (abs_next[i]) begin
                p_next = P_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: normalise and pack
    // ------------------------------------------------------------------
    always_comb begin
        // Leading one goes to bit 23 and is dropped (hidden bit), so the
        // bit below it lands at bit 22
        mant_next = 23'(24'(s1_abs_reg) << (5'd23 - 5'(s1_p_reg)));
`ifdef FP_TX_SCALE_EN
        exp_next  = 8'd127 + 8'(s1_p_reg) - 8'(SCALE_EXP);
`else
        exp_next  = 8'd127 + 8'(s1_p_reg);
`endif
        word_next = s1_zero_reg ? 32'h0000_0000
                                : {s1_sign_reg, exp_next, mant_next};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_abs_reg   <= '0;
            s1_p_reg     <= '0;
            s1_zero_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            data_reg     <= 32'h0000_0000;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            s1_valid_reg <= accept;
            if (accept) begin
                s1_sign_reg <= adc_data[SAMPLE_W-1];
                s1_abs_reg  <= abs_next;
                s1_p_reg    <= p_next;
                s1_zero_reg <= (abs_next == '0);
            end
            valid_reg <= s1_valid_reg;
            // data holds its last word between bursts
            if (s1_valid_reg) begin
                data_reg <= word_next;
            end
        end
    end

endmodule

// File: tb/tb_fp_sample_tx.sv
// ---------------------------------------------------------------------------
// tb_fp_sample_tx
//
// Directed bench for fp_sample_tx. A table of {sample, expected word}
// records drives full bursts; hand-written sequences cover input gaps,
// ignored go pulses, asynchronous reset mid-burst, a one-sample burst and
// (when FP_TX_SCALE_EN is defined) the scaled build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_sample_tx;

    typedef struct {
        logic [15:0] sample;
        logic [31:0] expd;
    } vec_t;

    vec_t vecs[12];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;

    // Main DUT, BURST_LEN = 6
    logic        go = 1'b0;
    logic [15:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        adc_ready;
    logic [31:0] data;
    logic        valid;
    logic        busy;
    logic        done;

    // Single-sample DUT, BURST_LEN = 1
    logic        go1 = 1'b0;
    logic [15:0] adc_data1 = '0;
    logic        adc_valid1 = 1'b0;
    logic        adc_ready1;
    logic [31:0] data1;
    logic        valid1;
    logic        busy1;
    logic        done1;

    logic [31:0] q_data[$];
    int          q_cyc[$];
    int          acc_cyc[$];
    int          done_cyc[$];
    logic [31:0] q1_data[$];
    int          q1_cyc[$];
    int          d1_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_sample_tx #(.SAMPLE_W(16), .BURST_LEN(6), .SCALE_EXP(0)) dut (
        .clk(clk), .rst(rst), .go(go),
        .adc_data(adc_data), .adc_valid(adc_valid), .adc_ready(adc_ready),
        .data(data), .valid(valid), .busy(busy), .done(done)
    );

    fp_sample_tx #(.SAMPLE_W(16), .BURST_LEN(1), .SCALE_EXP(0)) dut1 (
        .clk(clk), .rst(rst), .go(go1),
        .adc_data(adc_data1), .adc_valid(adc_valid1), .adc_ready(adc_ready1),
        .data(data1), .valid(valid1), .busy(busy1), .done(done1)
    );

`ifdef FP_TX_SCALE_EN
    logic        go2 = 1'b0;
    logic [15:0] adc_data2 = '0;
    logic        adc_valid2 = 1'b0;
    logic        adc_ready2;
    logic [31:0] data2;
    logic        valid2;
    logic        busy2;
    logic        done2;
    logic [31:0] q2_data[$];

    fp_sample_tx #(.SAMPLE_W(16), .BURST_LEN(2), .SCALE_EXP(1)) dut2 (
        .clk(clk), .rst(rst), .go(go2),
        .adc_data(adc_data2), .adc_valid(adc_valid2), .adc_ready(adc_ready2),
        .data(data2), .valid(valid2), .busy(busy2), .done(done2)
    );

    always @(negedge clk) begin
        if (valid2) q2_data.push_back(data2);
    end
`endif

    // Monitors sample on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (valid) begin
            q_data.push_back(data);
            q_cyc.push_back(cyc);
            $display("cycle %0d: word data=%h", cyc, data);
        end
        if (adc_valid && adc_ready) acc_cyc.push_back(cyc);
        if (done) done_cyc.push_back(cyc);
        if (valid1) begin
            q1_data.push_back(data1);
            q1_cyc.push_back(cyc);
            $display("cycle %0d: word1 data=%h", cyc, data1);
        end
        if (done1) d1_cyc.push_back(cyc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expd);
        n_total++;
        if (act === expd) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expd);
    endtask

    task automatic clear_q();
        q_data.delete(); q_cyc.delete(); acc_cyc.delete(); done_cyc.delete();
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 go = 1'b1;
        @(posedge clk); #1 go = 1'b0;
    endtask

    // Present one sample and hold it until accepted (bounded)
    task automatic send(input logic [15:0] s);
        int t = 0;
        adc_data  = s;
        adc_valid = 1'b1;
        @(negedge clk);
        while (!adc_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("send_ready", 32'(adc_ready), 32'd1);
        @(posedge clk); #1;
        adc_valid = 1'b0;
    endtask

    // Wait for done (bounded); optionally raise go in the DONE cycle
    task automatic wait_done(input bit go_in_done);
        int t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(done), 32'd1);
        if (go_in_done) begin
            go = 1'b1;
            @(posedge clk); #1 go = 1'b0;
        end
        #1;
    endtask

    task automatic check_burst(input int base);
        chk("word_count", 32'(q_data.size()), 32'd6);
        chk("accept_count", 32'(acc_cyc.size()), 32'd6);
        if (q_data.size() == 6 && acc_cyc.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("data[%0d]", base + i), q_data[i], vecs[base + i].expd);
                chk($sformatf("latency[%0d]", base + i), 32'(q_cyc[i] - acc_cyc[i]), 32'd2);
            end
        end
        chk("done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() == 1 && q_cyc.size() == 6) begin
            chk("done_after_last", 32'(done_cyc[0] - q_cyc[5]), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{16'd1,     32'h3F800000};
        vecs[1]  = '{16'd2,     32'h40000000};
        vecs[2]  = '{16'hFFFF,  32'hBF800000};
        vecs[3]  = '{16'd0,     32'h00000000};
        vecs[4]  = '{16'h7FFF,  32'h46FFFE00};
        vecs[5]  = '{16'h8000,  32'hC7000000};
        vecs[6]  = '{16'd3,     32'h40400000};
        vecs[7]  = '{16'hFFFB,  32'hC0A00000};
        vecs[8]  = '{16'd255,   32'h437F0000};
        vecs[9]  = '{16'hFF00,  32'hC3800000};
        vecs[10] = '{16'd1000,  32'h447A0000};
        vecs[11] = '{16'hFFFF,  32'hBF800000};

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_data", data, 32'h0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(adc_ready), 32'd0);

        // Burst 1: back-to-back samples
        clear_q();
        pulse_go();
        chk("busy_after_go", 32'(busy), 32'd1);
        chk("ready_after_go", 32'(adc_ready), 32'd1);
        for (int i = 0; i < 6; i++) send(vecs[i].sample);
        wait_done(1'b0);
        check_burst(0);
        @(negedge clk);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("valid_idle", 32'(valid), 32'd0);
        chk("data_holds", data, vecs[5].expd);

        // Burst 2: gaps on adc_valid, go during RUN and during DONE
        clear_q();
        pulse_go();
        for (int i = 0; i < 6; i++) begin
            send(vecs[6 + i].sample);
            if (i == 4) chk("ready_before_last", 32'(adc_ready), 32'd1);
            if (i == 5) chk("ready_after_last", 32'(adc_ready), 32'd0);
            if (i == 2) begin
                go = 1'b1;
                @(posedge clk); #1 go = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        wait_done(1'b1);
        check_burst(6);
        repeat (5) @(negedge clk);
        chk("no_restart_busy", 32'(busy), 32'd0);
        chk("no_restart_ready", 32'(adc_ready), 32'd0);
        chk("no_extra_words", 32'(q_data.size()), 32'd6);

        // Burst 3: asynchronous reset one cycle after the third accept
        clear_q();
        pulse_go();
        for (int i = 0; i < 3; i++) send(vecs[i].sample);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_data", data, 32'h0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ready", 32'(adc_ready), 32'd0);
        clear_q();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("arst_no_words", 32'(q_data.size()), 32'd0);
        chk("arst_no_done", 32'(done_cyc.size()), 32'd0);
        clear_q();
        pulse_go();
        for (int i = 0; i < 6; i++) send(vecs[6 + i].sample);
        wait_done(1'b0);
        check_burst(6);

        // BURST_LEN = 1, sample 100
        adc_data1  = 16'd100;
        adc_valid1 = 1'b1;
        @(posedge clk); #1 go1 = 1'b1;
        @(posedge clk); #1 go1 = 1'b0;
        repeat (10) @(negedge clk);
        adc_valid1 = 1'b0;
        chk("b1_word_count", 32'(q1_data.size()), 32'd1);
        chk("b1_done_count", 32'(d1_cyc.size()), 32'd1);
        if (q1_data.size() == 1 && d1_cyc.size() == 1) begin
            chk("b1_data", q1_data[0], 32'h42C80000);
            chk("b1_done_after", 32'(d1_cyc[0] - q1_cyc[0]), 32'd1);
        end

`ifdef FP_TX_SCALE_EN
        // Scaled build, SCALE_EXP = 1: samples 2 and 0
        @(posedge clk); #1 go2 = 1'b1;
        @(posedge clk); #1 go2 = 1'b0;
        adc_data2  = 16'd2;
        adc_valid2 = 1'b1;
        @(posedge clk); #1 adc_data2 = 16'd0;
        @(posedge clk); #1 adc_valid2 = 1'b0;
        repeat (8) @(negedge clk);
        chk("scale_count", 32'(q2_data.size()), 32'd2);
        if (q2_data.size() == 2) begin
            chk("scale_two", q2_data[0], 32'h3F800000);
            chk("scale_zero", q2_data[1], 32'h00000000);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
